nibble_serial_compare_ctrl: RTL and testbench

- Sequential controller that compares two WIDTH-bit unsigned operands using one shared 4-bit compare step, one nibble per clock, most-significant nibble first.
- Operands arrive on a valid/ready handshake; a registered equal/less/greater verdict leaves on a second valid/ready handshake.
- Replaces the wide combinational cascade of chained 4-bit comparators where area matters more than latency.

---
 rtl/nibble_serial_compare_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_nibble_serial_compare_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_compare_ctrl
//
// Purpose:
//   Compares two WIDTH-bit unsigned operands with one shared 4-bit compare
//   step, one nibble per clock, most-significant nibble first. The operands
//   arrive on a start valid/ready handshake. A registered equal/less/greater
//   verdict is returned on a result valid/ready handshake.
//
// Optional feature (compile-time macro):
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, RUN goes to DONE on the first
//   differing nibble, so latency depends on the data (1..NIB). When it is not
//   defined, all NIB nibbles are always stepped. The verdict is the same in
//   both builds; only the latency and `cycles` differ.
//
// Parameters:
//   WIDTH        operand width in bits; must be a multiple of 4 and >= 8
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   enable; low freezes RUN and drops start_ready
//   start_valid  in   operands a/b valid
//   start_ready  out  high only in IDLE with en=1 (and reset released)
//   a, b         in   operands, captured on the start handshake
//   res_valid    out  verdict valid (DONE state)
//   res_ready    in   consumer accepts the verdict
//   e, l, g      out  A==B, A<B, A>B (registered, held until next verdict)
//   busy         out  high in RUN or DONE
//   cycles       out  number of nibble steps used for the verdict
// -----------------------------------------------------------------------------
module nibble_serial_compare_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            e,
  output logic                            l,
  output logic                            g,
  output logic                            busy,
  output logic [$clog2(WIDTH/4+1)-1:0]    cycles
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Unsigned nibble compare: returns {x>y, x<y}.
  function automatic logic [1:0] nib_cmp(input logic [3:0] x, input logic [3:0] y);
    nib_cmp = {(x > y), (x < y)};
  endfunction

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic             r_g_pend;
  logic             r_l_pend;
  logic             r_e;
  logic             r_l;
  logic             r_g;
  logic [CW-1:0]    r_cycles;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [1:0]       w_cmp;
  logic             w_diff;
  logic             w_dec_now;
  logic             w_g_now;
  logic             w_l_now;
  logic             w_last;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_start_ready;
  logic             w_accept;

  // Nibble select as an explicit mux over the NIB positions, so only the
  // selected 4 bits of each operand register feed the shared comparator.
  always_comb begin
    w_nib_a = 4'd0;
    w_nib_b = 4'd0;
    for (int k = 0; k < NIB; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib_a = r_a[4*k +: 4];
        w_nib_b = r_b[4*k +: 4];
      end
    end
  end

  assign w_cmp     = nib_cmp(w_nib_a, w_nib_b);
  assign w_diff    = w_cmp[1] | w_cmp[0];
  assign w_cnt_nxt = r_cnt + CW'(1);

  // A decision latched on an earlier (more significant) nibble always wins
  // over whatever the current nibble says.
  assign w_dec_now = r_decided | w_diff;
  assign w_g_now   = r_decided ? r_g_pend : w_cmp[1];
  assign w_l_now   = r_decided ? r_l_pend : w_cmp[0];

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // The first difference settles the verdict, so stop right there.
  assign w_last = (r_idx == '0) | (w_diff & ~r_decided);
`else
  assign w_last = (r_idx == '0);
`endif

  // start_ready is forced low while reset is held, independent of en.
  assign w_start_ready = (r_state == S_IDLE) & en & rst_n;
  assign w_accept      = start_valid & w_start_ready;

  assign start_ready = w_start_ready;
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) | (r_state == S_DONE);
  assign e           = r_e;
  assign l           = r_l;
  assign g           = r_g;
  assign cycles      = r_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_g_pend  <= 1'b0;
      r_l_pend  <= 1'b0;
      r_e       <= 1'b0;
      r_l       <= 1'b0;
      r_g       <= 1'b0;
      r_cycles  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= IW'(NIB - 1);
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_g_pend  <= 1'b0;
            r_l_pend  <= 1'b0;
            r_state   <= S_RUN;
          end
        end

        S_RUN: begin
          // With en low every RUN register simply holds.
          if (en) begin
            r_cnt <= w_cnt_nxt;
            if (!r_decided && w_diff) begin
              r_decided <= 1'b1;
              r_g_pend  <= w_cmp[1];
              r_l_pend  <= w_cmp[0];
            end
            if (w_last) begin
              // Output registers are only ever rewritten here, on DONE entry.
              r_state  <= S_DONE;
              r_e      <= ~w_dec_now;
              r_g      <= w_g_now;
              r_l      <= w_l_now;
              r_cycles <= w_cnt_nxt;
            end else begin
              r_idx <= r_idx - IW'(1);
            end
          end
        end

        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
module tb_nibble_serial_compare_ctrl;

  localparam int WIDTH = 32;
  localparam int CW    = 4;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int M_MSB  = 1;
  localparam int M_IDX1 = 7;
`else
  localparam int M_MSB  = 8;
  localparam int M_IDX1 = 8;
`endif
  localparam int M_FULL = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic             e;
  logic             l;
  logic             g;
  logic             busy;
  logic [CW-1:0]    cycles;

  int n_tests;
  int n_fail;

  nibble_serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .e           (e),
    .l           (l),
    .g           (g),
    .busy        (busy),
    .cycles      (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands at a falling edge once start_ready is up; returns just
  // after the accepting rising edge (edge 0) with start_valid dropped.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!start_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_accept: start_ready=%b required 1 within 20 cycles", start_ready);
    end
    start_valid = 1'b1;
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Counts rising edges after edge 0 until res_valid is seen (bounded).
  task automatic wait_res(inout int lat);
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic finish_handshake;
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b1;
    #3;
    n_tests++;
    if (start_ready !== 1'b0) begin n_fail++; $display("FAIL reset_start_ready: got %b required 0", start_ready); end
    n_tests++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++;
    if ({e, l, g} !== 3'b000) begin n_fail++; $display("FAIL reset_elg: got %b required 000", {e, l, g}); end
    n_tests++;
    if (cycles !== 4'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d required 0", cycles); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", start_ready); end
    en = 1'b0;
    #1;
    n_tests++;
    if (start_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready: got %b required 0", start_ready); end
    en = 1'b1;
  endtask

  task automatic test_equal;
    int lat;
    start_op(32'h12345678, 32'h12345678);
    lat = 0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL eq_busy: got %b required 1", busy); end
    wait_res(lat);
    n_tests++;
    if (lat != M_FULL) begin n_fail++; $display("FAIL eq_latency: got %0d required %0d", lat, M_FULL); end
    n_tests++;
    if ({e, l, g} !== 3'b100) begin n_fail++; $display("FAIL eq_elg: got %b required 100", {e, l, g}); end
    n_tests++;
    if (cycles !== 4'(M_FULL)) begin n_fail++; $display("FAIL eq_cycles: got %0d required %0d", cycles, M_FULL); end
    finish_handshake();
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL eq_after_hs: res_valid=%b busy=%b required 0 0", res_valid, busy);
    end
    n_tests++;
    if ({e, l, g} !== 3'b100 || cycles !== 4'(M_FULL)) begin
      n_fail++; $display("FAIL eq_hold_in_idle: elg=%b cycles=%0d required 100 %0d", {e, l, g}, cycles, M_FULL);
    end
  endtask

  task automatic test_msb_diff;
    int lat;
    start_op(32'h80000000, 32'h7FFFFFFF);
    lat = 0;
    wait_res(lat);
    n_tests++;
    if (lat != M_MSB) begin n_fail++; $display("FAIL msb_latency: got %0d required %0d", lat, M_MSB); end
    n_tests++;
    if ({e, l, g} !== 3'b001) begin n_fail++; $display("FAIL msb_elg: got %b required 001", {e, l, g}); end
    n_tests++;
    if (cycles !== 4'(M_MSB)) begin n_fail++; $display("FAIL msb_cycles: got %0d required %0d", cycles, M_MSB); end
    finish_handshake();
  endtask

  task automatic test_low_diff;
    int lat;
    start_op(32'h1234567F, 32'h12345680);
    lat = 0;
    wait_res(lat);
    n_tests++;
    if (lat != M_IDX1) begin n_fail++; $display("FAIL low_latency: got %0d required %0d", lat, M_IDX1); end
    n_tests++;
    if ({e, l, g} !== 3'b010) begin n_fail++; $display("FAIL low_elg: got %b required 010", {e, l, g}); end
    n_tests++;
    if (cycles !== 4'(M_IDX1)) begin n_fail++; $display("FAIL low_cycles: got %0d required %0d", cycles, M_IDX1); end
    finish_handshake();
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(32'h000000A0, 32'h000000B0);
    lat = 0;
    wait_res(lat);
    n_tests++;
    if ({e, l, g} !== 3'b010 || cycles !== 4'(M_IDX1)) begin
      n_fail++; $display("FAIL bp_first: elg=%b cycles=%0d required 010 %0d", {e, l, g}, cycles, M_IDX1);
    end
    @(negedge clk);
    start_valid = 1'b1;
    a = 32'hFFFFFFFF;
    b = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || {e, l, g} !== 3'b010 || cycles !== 4'(M_IDX1)) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: res_valid=%b start_ready=%b elg=%b cycles=%0d required 1 0 010 %0d",
                 i, res_valid, start_ready, {e, l, g}, cycles, M_IDX1);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    n_tests++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle_after_hs: start_ready=%b busy=%b required 1 0", start_ready, busy);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_accept: busy=%b start_ready=%b required 1 0", busy, start_ready);
    end
    lat = 0;
    wait_res(lat);
    n_tests++;
    if (lat != M_MSB || {e, l, g} !== 3'b001 || cycles !== 4'(M_MSB)) begin
      n_fail++; $display("FAIL bp_second: lat=%0d elg=%b cycles=%0d required %0d 001 %0d",
                         lat, {e, l, g}, cycles, M_MSB, M_MSB);
    end
    finish_handshake();
  endtask

  task automatic test_en_stall;
    int lat;
    start_op(32'h0000000F, 32'h00000010);
    lat = 0;
    repeat (2) begin
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_state: busy=%b res_valid=%b required 1 0", busy, res_valid);
    end
    en = 1'b1;
    #1;
    wait_res(lat);
    n_tests++;
    if (lat != M_IDX1 + 3) begin n_fail++; $display("FAIL stall_latency: got %0d required %0d", lat, M_IDX1 + 3); end
    n_tests++;
    if ({e, l, g} !== 3'b010) begin n_fail++; $display("FAIL stall_elg: got %b required 010", {e, l, g}); end
    n_tests++;
    if (cycles !== 4'(M_IDX1)) begin n_fail++; $display("FAIL stall_cycles: got %0d required %0d", cycles, M_IDX1); end
    finish_handshake();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int seen;
    start_op(32'h12345678, 32'h12345678);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: res_valid=%b busy=%b start_ready=%b required 0 0 0",
                         res_valid, busy, start_ready);
    end
    n_tests++;
    if ({e, l, g} !== 3'b000 || cycles !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid_outs: elg=%b cycles=%0d required 000 0", {e, l, g}, cycles);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_result: busy/res_valid cycles=%0d required 0", seen); end
    start_op(32'h00000005, 32'h00000003);
    lat = 0;
    wait_res(lat);
    n_tests++;
    if (lat != M_FULL || {e, l, g} !== 3'b001 || cycles !== 4'(M_FULL)) begin
      n_fail++; $display("FAIL rst_fresh_op: lat=%0d elg=%b cycles=%0d required %0d 001 %0d",
                         lat, {e, l, g}, cycles, M_FULL, M_FULL);
    end
    finish_handshake();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    test_reset();
    test_equal();
    test_msb_diff();
    test_low_diff();
    test_backpressure();
    test_en_stall();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
